// File: rtl/mod_reduce.sv
// mod_reduce: restoring shift-subtract reduction of prod by modulus, one dividend
// bit per cycle, with a valid/ready handshake on both sides.
module mod_reduce #(
  parameter int W_IN  = 12,
  parameter int W_MOD = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W_IN-1:0]  prod,
  input  logic [W_MOD-1:0] modulus,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W_MOD-1:0] rem,
  output logic [W_IN-1:0]  quot,
  output logic             err
);
  localparam int CW = W_IN > 1 ? $clog2(W_IN) : 1;
  localparam logic [1:0] IDLE = 2'd0, DIV = 2'd1, HOLD = 2'd2;
  logic [1:0]       state_q;
  logic [W_IN-1:0]  prod_q, qw_q, qw_d, quot_q;
  logic [W_MOD-1:0] mod_q, rem_q;
  logic [W_MOD:0]   r_q, r_d, t;
  logic [CW-1:0]    cnt_q;
  logic             err_q, ge;
  // One restoring step; r_q stays below mod_q, so its top bit is dropped in the shift.
  always_comb begin
    t    = {r_q[W_MOD-1:0], prod_q[cnt_q]};
    ge   = t >= {1'b0, mod_q};
    r_d  = ge ? t - {1'b0, mod_q} : t;
    qw_d = {qw_q[W_IN-2:0], ge};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prod_q  <= '0;
      mod_q   <= '0;
      r_q     <= '0;
      qw_q    <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          prod_q <= prod;
          mod_q  <= modulus;
          r_q    <= '0;
          cnt_q  <= CW'(W_IN - 1);
          if (modulus == '0) begin
            state_q <= HOLD;
            err_q   <= 1'b1;
            rem_q   <= '0;
            quot_q  <= '1;
          end else state_q <= DIV;
        end
        DIV: begin
          r_q   <= r_d;
          qw_q  <= qw_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == '0) begin
            state_q <= HOLD;
            rem_q   <= r_d[W_MOD-1:0];
            quot_q  <= qw_d;
            err_q   <= 1'b0;
          end
        end
        HOLD: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == HOLD;
  assign rem       = rem_q;
  assign quot      = quot_q;
  assign err       = err_q;
endmodule

// File: doc/mod_reduce.md
MOD_REDUCE -- requirements
Module: mod_reduce

Interface
REQ-001 The block SHALL have parameter W_IN, default 12, giving the width of the product operand.
REQ-002 The block SHALL have parameter W_MOD, default 6, giving the width of the modulus and remainder.
REQ-003 Port clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port in_valid  input  1  prod/modulus valid this cycle.
REQ-006 Port in_ready  output  1  block can accept an operand pair.
REQ-007 Port prod  input  W_IN  dividend (multiplier product).
REQ-008 Port modulus  input  W_MOD  divisor N.
REQ-009 Port out_valid  output  1  rem/quot/err valid.
REQ-010 Port out_ready  input  1  consumer accepts result.
REQ-011 Port rem  output  W_MOD  prod mod modulus.
REQ-012 Port quot  output  W_IN  floor(prod / modulus).
REQ-013 Port err  output  1  divide-by-zero flag, qualified by out_valid.

Function
REQ-014 States SHALL be IDLE, DIV and HOLD.
REQ-015 in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in HOLD.
REQ-016 Accept: when in_valid and in_ready are both 1 at edge k, prod and modulus SHALL be registered internally; later input changes SHALL have no effect on that operation.
REQ-017 If the registered modulus is nonzero, the block SHALL go IDLE->DIV at edge k with the bit counter = W_IN-1 and the partial remainder = 0.
REQ-018 If the registered modulus is 0, the block SHALL go IDLE->HOLD at edge k with err=1, rem=0 and quot=all-ones; out_valid SHALL be 1 from edge k.
REQ-019 DIV SHALL use restoring shift-subtract, MSB first, one dividend bit per cycle: t = {r, prod[i]} (W_MOD+1 bits); if t >= modulus then r = t - modulus and quot[i] = 1, else r = t[W_MOD-1:0] and quot[i] = 0.
REQ-020 The partial remainder SHALL be W_MOD+1 bits wide internally so that no intermediate overflows for any modulus up to 2^W_MOD-1.
REQ-021 After the iteration with i=0 (edge k+W_IN, i.e. k+12 at defaults), the block SHALL enter HOLD with err=0; out_valid SHALL be 1 from that edge.
REQ-022 Latency SHALL be fixed at W_IN cycles from accept to out_valid for nonzero modulus, independent of operand values.
REQ-023 HOLD SHALL keep rem, quot and err stable while out_ready=0 (back-pressure, no timeout).
REQ-024 HOLD->IDLE SHALL occur at the edge where out_valid=1 and out_ready=1; in_ready SHALL be 1 in the following cycle, so at most one operation is in flight.
REQ-025 An in_valid asserted during DIV or HOLD SHALL be ignored, not queued.
REQ-026 A modulus of 1 SHALL yield rem=0 and quot=prod; prod < modulus SHALL yield rem=prod and quot=0.
REQ-027 rem and quot SHALL retain their last values in IDLE and DIV; they SHALL be meaningful only while out_valid=1.

Reset
REQ-028 While rst=1 at an edge, the block SHALL enter IDLE with in_ready=1, out_valid=0, err=0, rem=0, quot=0, the partial remainder cleared and the counter cleared.
REQ-029 rst SHALL take priority over every other input in any state; an operation interrupted in DIV or HOLD SHALL be discarded, with no out_valid for it.
REQ-030 When rst=1 and in_valid=1 at the same edge, the operand SHALL NOT be accepted.

Verification
REQ-031 prod=3025 (55*55), modulus=21, out_ready=1 -> out_valid exactly 12 cycles after accept, rem=1, quot=144, err=0.
REQ-032 prod=4095, modulus=63 -> rem=0, quot=65; prod=20, modulus=21 -> rem=20, quot=0; prod=37, modulus=1 -> rem=0, quot=37.
REQ-033 modulus=0, prod=100 -> out_valid at the edge following accept, err=1, rem=0, quot=4095; the next operation with a nonzero modulus computes normally.
REQ-034 Back-pressure: hold out_ready=0 for 5 cycles after out_valid -> outputs stable and in_ready=0 throughout; in_valid pulses in that window are ignored; the result retires on the first out_ready=1.
REQ-035 Reset mid-operation: assert rst for 1 cycle 6 cycles after accept -> IDLE next cycle, in_ready=1, out_valid never asserted for the aborted operation; the following operation (prod=3025, modulus=21) returns rem=1.
REQ-036 Back-to-back: in_valid held high with out_ready=1 -> a new accept every 14 cycles (accept, 12 DIV, 1 HOLD), each result correct against a reference model over random prod and modulus in 1..63.
